// File: rtl/sc_spi_seq.sv
// SPI frame sequencer: splits one command into 1-16 back-to-back controller
// frames, sourcing TX words from and capturing RX words into 16x32 buffers.
module sc_spi_seq #(
  parameter int NUM_OF_CS = 32
) (
  input  logic        SPICLK,
  input  logic        SYSRST,
  input  logic        BUFWE,
  input  logic [3:0]  BUFWADDR,
  input  logic [31:0] BUFWDATA,
  input  logic [3:0]  BUFRADDR,
  output logic [31:0] BUFRDATA,
  input  logic        CMDVALID,
  output logic        CMDREADY,
  input  logic [4:0]  CMD_NFRAME,
  input  logic [4:0]  CMD_CSSEL,
  input  logic [8:0]  CMD_DWIDTH,
  input  logic        CMD_KEEPCS,
  input  logic [3:0]  CMD_GAP,
  input  logic        ABORT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        ABORTED,
  output logic        SPISTART,
  input  logic        SPIBUSY,
  output logic [4:0]  CSSEL,
  output logic [8:0]  DWIDTH,
  output logic        CSEXTEND,
  output logic [31:0] TXDATA,
  input  logic [3:0]  TXDPT,
  input  logic [31:0] RXDATA,
  input  logic        RXVALID,
  input  logic [3:0]  RXDPT
);

  // The chip-select index stays 5 bits wide whatever NUM_OF_CS is.
  if (NUM_OF_CS < 1) begin : g_no_cs
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WBUSY, S_XFER, S_DRAIN, S_GAPW, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cssel_q, cssel_d;
  logic [8:0]  dwidth_q, dwidth_d;
  logic [4:0]  nframe_q, nframe_d;
  logic        keepcs_q, keepcs_d;
  logic [3:0]  gap_q, gap_d;
  logic [4:0]  fidx_q, fidx_d;
  logic [3:0]  base_q, base_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        csextend_q, csextend_d;
  logic        aborted_q, aborted_d;
  logic        err_q, err_d;

  logic [31:0] txbuf_q [16];
  logic [31:0] rxbuf_q [16];

  logic [8:0]  cmd_tot;
  logic        cmd_ok;
  logic        last_frame;
  logic        advance;
  logic        rx_we;
  logic [3:0]  rx_addr;

  // Total words = NFRAME * (DWIDTH[8:5] + 1), kept 9 bits so oversize products are visible.
  assign cmd_tot    = ({4'd0, CMD_NFRAME} * {5'd0, CMD_DWIDTH[8:5]}) + {4'd0, CMD_NFRAME};
  assign cmd_ok     = (CMD_NFRAME != 5'd0) && (CMD_NFRAME <= 5'd16) && (cmd_tot <= 9'd16);
  assign last_frame = (fidx_q == (nframe_q - 5'd1));

  always_comb begin
    state_d    = state_q;
    cssel_d    = cssel_q;
    dwidth_d   = dwidth_q;
    nframe_d   = nframe_q;
    keepcs_d   = keepcs_q;
    gap_d      = gap_q;
    fidx_d     = fidx_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    csextend_d = csextend_q;
    aborted_d  = aborted_q;
    err_d      = 1'b0;
    advance    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CMDVALID) begin
          if (cmd_ok) begin
            state_d    = S_START;
            cssel_d    = CMD_CSSEL;
            dwidth_d   = CMD_DWIDTH;
            nframe_d   = CMD_NFRAME;
            keepcs_d   = CMD_KEEPCS;
            gap_d      = CMD_GAP;
            fidx_d     = 5'd0;
            base_d     = 4'd0;
            csextend_d = (CMD_NFRAME > 5'd1) ? 1'b1 : CMD_KEEPCS;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START: state_d = S_WBUSY;
      S_WBUSY: begin
        if (SPIBUSY) state_d = S_XFER;
      end
      S_XFER: begin
        if (!SPIBUSY) begin
          state_d = S_DRAIN;
          cnt_d   = 4'd0;
        end
      end
      S_DRAIN: begin
        // Two cycles so a late final RXVALID still lands in the RX buffer.
        if (cnt_q == 4'd1) begin
          if (last_frame || ABORT) begin
            state_d   = S_FIN;
            aborted_d = ABORT && !last_frame;
            if (ABORT && !last_frame) csextend_d = 1'b0;
          end else if (gap_q == 4'd0) begin
            advance = 1'b1;
          end else begin
            state_d = S_GAPW;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAPW: begin
        if (cnt_q == (gap_q - 4'd1)) advance = 1'b1;
        else cnt_d = cnt_q + 4'd1;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      state_d    = S_START;
      fidx_d     = fidx_q + 5'd1;
      base_d     = base_q + dwidth_q[8:5] + 4'd1;
      csextend_d = ((fidx_q + 5'd2) < nframe_q) ? 1'b1 : keepcs_q;
    end
  end

  always_ff @(posedge SPICLK or posedge SYSRST) begin
    if (SYSRST) begin
      state_q    <= S_IDLE;
      cssel_q    <= 5'd0;
      dwidth_q   <= 9'd0;
      nframe_q   <= 5'd0;
      keepcs_q   <= 1'b0;
      gap_q      <= 4'd0;
      fidx_q     <= 5'd0;
      base_q     <= 4'd0;
      cnt_q      <= 4'd0;
      csextend_q <= 1'b0;
      aborted_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cssel_q    <= cssel_d;
      dwidth_q   <= dwidth_d;
      nframe_q   <= nframe_d;
      keepcs_q   <= keepcs_d;
      gap_q      <= gap_d;
      fidx_q     <= fidx_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      csextend_q <= csextend_d;
      aborted_q  <= aborted_d;
      err_q      <= err_d;
    end
  end

  // Buffer contents survive reset.
  assign rx_we   = RXVALID && ((state_q == S_XFER) || (state_q == S_DRAIN));
  assign rx_addr = base_q + RXDPT;

  always_ff @(posedge SPICLK) begin
    if (BUFWE) txbuf_q[BUFWADDR] <= BUFWDATA;
    if (rx_we) rxbuf_q[rx_addr] <= RXDATA;
  end

  assign TXDATA   = txbuf_q[base_q + TXDPT];
  assign BUFRDATA = rxbuf_q[BUFRADDR];
  assign CMDREADY = (state_q == S_IDLE);
  assign BUSY     = (state_q != S_IDLE);
  assign SPISTART = (state_q == S_START);
  assign DONE     = (state_q == S_FIN);
  assign ERR      = err_q;
  assign ABORTED  = aborted_q;
  assign CSSEL    = cssel_q;
  assign DWIDTH   = dwidth_q;
  assign CSEXTEND = csextend_q;

endmodule
